kbd_ctrl: RTL

PDP-8 console keyboard controller (device 03) that sequences the 8N1 UART receiver. Generates the receiver's 16x baud strobe and drains completed characters into a 4-entry FIFO using the receiver's rdy/read handshake. Executes keyboard IOTs from the CPU (KCF/KSF/KCC/KRS/KIE/KRB) and drives the keyboard flag and interrupt request.

---
 rtl/kbd_ctrl_if.sv | 33 +++
 rtl/kbd_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/kbd_ctrl_if.sv
// Signal bundle between the keyboard controller, the 8N1 receiver and the CPU IOT bus.
// The slave modport is the controller's view; master is the surrounding system's view.
interface kbd_ctrl_if;
   logic        mclkx16;
   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        rx_err;
   logic        rx_read;
   logic        iot;
   logic [5:0]  iot_dev;
   logic [2:0]  iot_op;
   logic [11:0] ac_in;
   logic        iot_done;
   logic        skip;
   logic        ac_clr;
   logic [11:0] ac_or;
   logic        kbd_flag;
   logic        kbd_err;
   logic        irq;
   logic [2:0]  fifo_cnt;

   modport slave (
      input  rx_rdy, rx_data, rx_err, iot, iot_dev, iot_op, ac_in,
      output mclkx16, rx_read, iot_done, skip, ac_clr, ac_or,
             kbd_flag, kbd_err, irq, fifo_cnt
   );

   modport master (
      output rx_rdy, rx_data, rx_err, iot, iot_dev, iot_op, ac_in,
      input  mclkx16, rx_read, iot_done, skip, ac_clr, ac_or,
             kbd_flag, kbd_err, irq, fifo_cnt
   );
endinterface

// File: rtl/kbd_ctrl.sv
// PDP-8 console keyboard controller: 16x baud strobe, receiver drain into a small FIFO,
// and execution of keyboard IOTs with flag and interrupt generation.
module kbd_ctrl #(
   parameter int         CLK_HZ     = 50000000,
   parameter int         BAUD       = 9600,
   parameter logic [5:0] DEV        = 6'o03,
   parameter int         DEPTH_LOG2 = 2
) (
   input logic       clk,
   input logic       rst,
   kbd_ctrl_if.slave bus
);
   localparam int DIV_RAW = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int BW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [BW-1:0]       DIV_LAST = BW'(DIV - 1);
   localparam logic [DEPTH_LOG2:0] CNT_FULL = DEPTH[DEPTH_LOG2:0];

   typedef enum logic {S_IDLE, S_WAIT} drain_state_t;

   drain_state_t          state;
   logic [BW-1:0]         baud_cnt;
   logic                  rx_read_q;
   logic [8:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   cnt, cnt_next;
   logic [8:0]            head;
   logic                  empty, push, pop, iot_hit, is_kie, flag_clr, head_new;
   logic                  head_evt, flag, ie;
   logic                  iot_done_q, skip_q, ac_clr_q;
   logic [11:0]           ac_or_q;
   logic                  unused_ok;

   always_ff @(posedge clk) begin
      if (!rst)                     baud_cnt <= '0;
      else if (baud_cnt == DIV_LAST) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;
   end

   assign empty    = (cnt == '0);
   assign head     = mem[rd_ptr];
   assign iot_hit  = bus.iot && (bus.iot_dev == DEV);
   assign is_kie   = (bus.iot_op == 3'b101);
   assign push     = (state == S_IDLE) && bus.rx_rdy && (cnt < CNT_FULL);
   assign pop      = iot_hit && !is_kie && bus.iot_op[1] && !empty;
   assign flag_clr = iot_hit && !is_kie && (bus.iot_op[1] || (bus.iot_op == 3'b000));

   always_comb begin
      cnt_next = cnt;
      if (push && !pop)      cnt_next = cnt + 1'b1;
      else if (pop && !push) cnt_next = cnt - 1'b1;
   end

   // The head becomes newly valid on a push into an empty FIFO or a pop that leaves data behind.
   assign head_new = (push && empty) || (pop && (cnt_next != '0));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         rx_read_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               rx_read_q <= push;
               if (push) state <= S_WAIT;
            end
            S_WAIT: begin
               rx_read_q <= 1'b0;
               if (!bus.rx_rdy) state <= S_IDLE;
            end
            default: begin
               rx_read_q <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push) mem[wr_ptr] <= {bus.rx_err, bus.rx_data};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         head_evt   <= 1'b0;
         flag       <= 1'b0;
         ie         <= 1'b1;
         iot_done_q <= 1'b0;
         skip_q     <= 1'b0;
         ac_clr_q   <= 1'b0;
         ac_or_q    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt      <= cnt_next;
         head_evt <= head_new;

         // A clear wins over a pending set; the lost set is not retried until the next head event.
         if (flag_clr)      flag <= 1'b0;
         else if (head_evt) flag <= 1'b1;

         iot_done_q <= iot_hit;
         if (iot_hit && is_kie) ie <= bus.ac_in[0];
         if (iot_hit && !is_kie) begin
            skip_q   <= bus.iot_op[0] & flag;
            ac_clr_q <= bus.iot_op[1];
            ac_or_q  <= (bus.iot_op[2] && !empty) ? {4'h0, head[7:0]} : 12'h000;
         end else begin
            skip_q   <= 1'b0;
            ac_clr_q <= 1'b0;
            ac_or_q  <= 12'h000;
         end
      end
   end

   assign bus.mclkx16  = rst && (baud_cnt == DIV_LAST);
   assign bus.rx_read  = rx_read_q && rst;
   assign bus.iot_done = iot_done_q;
   assign bus.skip     = skip_q;
   assign bus.ac_clr   = ac_clr_q;
   assign bus.ac_or    = ac_or_q;
   assign bus.kbd_flag = flag;
   assign bus.kbd_err  = !empty && head[8];
   assign bus.irq      = flag && ie;
   assign bus.fifo_cnt = 3'(cnt);
   assign unused_ok    = ^bus.ac_in[11:1];
endmodule
